cuts_tape_tx: RTL
=================

CUTS_TAPE_TX -- requirements
Module: cuts_tape_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 32000000: clk_sys frequency in Hz, range 48000..67108863.
REQ-002 SHALL have parameter STOP_BITS, default 1: number of stop cells per byte, range 1..2.
REQ-003 SHALL have port clk_sys  in  1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n  in  1: reset, asynchronous and active-low.
REQ-005 SHALL have port enable  in  1: tape motor/record enable, active-high.
REQ-006 SHALL have port din  in  8: byte to transmit.
REQ-007 SHALL have port din_valid  in  1: din is valid.
REQ-008 SHALL have port din_ready  out  1: holding register can accept a byte.
REQ-009 SHALL have port tape_out  out  1: CUTS square-wave tape signal.
REQ-010 SHALL have port busy  out  1: a byte is held or in transmission.

Function
REQ-011 SHALL generate a 4800 Hz tick with a 26-bit fractional accumulator: add 4800 each clock; on reaching or exceeding CLK_HZ, subtract CLK_HZ and assert tick for one clock; exactly 4800 ticks per CLK_HZ clocks, no drift.
REQ-012 SHALL hold the accumulator at 0 while state = IDLE.
REQ-013 SHALL define a bit cell as 16 ticks (300 baud), counted by a 4-bit cell_cnt that increments on tick and wraps 15->0.
REQ-014 SHALL, in a mark cell (bit 1), toggle tape_out on every tick: 8 cycles of 2400 Hz.
REQ-015 SHALL, in a space cell (bit 0), toggle tape_out on ticks where the pre-increment cell_cnt is odd: 8 toggles, 4 cycles of 1200 Hz.
REQ-016 SHALL have states IDLE, CARRIER, START, DATA, STOP; cell value CARRIER=1, START=0, DATA=shift[0], STOP=1.
REQ-017 SHALL, in IDLE with enable=1, go to CARRIER next clock with tape_out=1, cell_cnt=0, and accumulator=0.
REQ-018 SHALL have a one-byte holding register: din_ready = enable & ~hold_full & ~IDLE; a transfer occurs when din_valid & din_ready; it sets hold_full and latches din.
REQ-019 SHALL evaluate the next cell only at the cell boundary (tick & cell_cnt=15), using the registered hold_full value; a byte accepted on the boundary clock waits for the next boundary.
REQ-020 SHALL, at the boundary from CARRIER or the last STOP cell: go to START if hold_full, loading shift<=hold and clearing hold_full; otherwise go to CARRIER.
REQ-021 SHALL, at the boundary, go START->DATA with bit_idx=0; in DATA shift right LSB-first, bit_idx 0..7; after bit 7 go to STOP; after STOP_BITS cells follow REQ-020.
REQ-022 SHALL make back-to-back bytes contiguous: no carrier cell between the last stop cell and the next start cell when hold_full.
REQ-023 SHALL set busy = hold_full | (state in START, DATA, STOP).
REQ-024 SHALL, when enable=0 in any non-IDLE state, go to IDLE on the next clock, with tape_out=0 and hold_full=0; a partial byte is discarded.
REQ-025 SHALL, with simultaneous enable fall and din transfer, give the abort priority; the byte is dropped.

Reset
REQ-026 SHALL, while reset_n=0, immediately force: state=IDLE, tape_out=0, din_ready=0, busy=0, hold_full=0, accumulator=0, cell_cnt=0, bit_idx=0.
REQ-027 SHALL, after release, behave as IDLE; a reset mid-byte loses that byte with no glitch on tape_out beyond going to 0.

Verification (CLK_HZ=48000 unless stated: tick every 10 clocks, cell every 160 clocks)
REQ-028 SHALL cover: enable=1 with no data -> tape_out=1, then toggles every 10 clocks indefinitely; din_ready=1; busy=0.
REQ-029 SHALL cover: byte 0x55 accepted in CARRIER -> at the next boundary, cells 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop); space cells toggle every 20 clocks; then CARRIER; busy falls at the end of the stop cell.
REQ-030 SHALL cover: 0x00 then 0xFF offered with din_valid held high -> the second byte is accepted while the first transmits; 20 contiguous cells, no carrier gap; STOP_BITS=2 gives 22 cells.
REQ-031 SHALL cover: enable dropped during DATA bit 3 -> next clock tape_out=0, busy=0, din_ready=0; re-enable restarts with a carrier cell.
REQ-032 SHALL cover: reset_n asserted mid-START -> all outputs 0 asynchronously, before the next clk_sys edge.
REQ-033 SHALL cover: CLK_HZ=32000000, enable held -> exactly 4800 ticks (tape_out toggles) in 32000000 clocks; tick spacing only 6666 or 6667 clocks.

Source files
------------

// File: rtl/cuts_tape_tx.sv
// CUTS (Kansas City 300 baud) tape transmitter.
// Serialises bytes into 1200/2400 Hz square-wave cells.
module cuts_tape_tx #(
  parameter int CLK_HZ    = 32000000,
  parameter int STOP_BITS = 1
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       tape_out,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    CARRIER,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [26:0] STEP  = 27'd4800;
  localparam logic [26:0] LIMIT = 27'(CLK_HZ);
  localparam logic LAST_STOP    = (STOP_BITS == 2);

  state_t      state, state_d;
  logic [25:0] acc, acc_d;
  logic [3:0]  cell_cnt, cell_d;
  logic [2:0]  bit_idx, bit_d;
  logic        stop_cnt, stop_d;
  logic [7:0]  shift, shift_d;
  logic [7:0]  hold, hold_d;
  logic        hold_full, hold_full_d;
  logic        tape_d;

  logic [26:0] sum;
  logic        tick;
  logic        cell_val;
  logic        boundary;
  logic        xfer;

  // Baud accumulator, cell decode and handshake terms.
  always_comb begin
    sum      = {1'b0, acc} + STEP;
    tick     = (state != IDLE) && (sum >= LIMIT);
    boundary = tick && (cell_cnt == 4'hF);
    case (state)
      CARRIER: cell_val = 1'b1;
      STOP:    cell_val = 1'b1;
      DATA:    cell_val = shift[0];
      default: cell_val = 1'b0;
    endcase
    din_ready = enable & ~hold_full & (state != IDLE);
    xfer      = din_valid & din_ready;
    busy      = hold_full |
                (state == START) |
                (state == DATA) |
                (state == STOP);
  end

  // Next-state logic for the cell sequencer and holding register.
  always_comb begin
    state_d     = state;
    acc_d       = acc;
    cell_d      = cell_cnt;
    bit_d       = bit_idx;
    stop_d      = stop_cnt;
    shift_d     = shift;
    hold_d      = hold;
    hold_full_d = hold_full;
    tape_d      = tape_out;
    if (state == IDLE) begin
      acc_d  = '0;
      cell_d = '0;
      tape_d = 1'b0;
      if (enable) begin
        state_d = CARRIER;
        tape_d  = 1'b1;
      end
    end else if (!enable) begin
      // Abort wins over a same-cycle transfer.
      state_d     = IDLE;
      acc_d       = '0;
      cell_d      = '0;
      tape_d      = 1'b0;
      hold_full_d = 1'b0;
    end else begin
      if (xfer) begin
        hold_full_d = 1'b1;
        hold_d      = din;
      end
      if (tick) begin
        acc_d  = 26'(sum - LIMIT);
        cell_d = cell_cnt + 4'd1;
        if (cell_val | cell_cnt[0])
          tape_d = ~tape_out;
      end else begin
        acc_d = sum[25:0];
      end
      if (boundary) begin
        case (state)
          START: begin
            state_d = DATA;
            bit_d   = '0;
          end
          DATA: begin
            shift_d = shift >> 1;
            if (bit_idx == 3'd7) begin
              state_d = STOP;
              stop_d  = 1'b0;
            end else begin
              bit_d = bit_idx + 3'd1;
            end
          end
          default: begin
            if (state == STOP && stop_cnt != LAST_STOP) begin
              stop_d = 1'b1;
            end else if (hold_full) begin
              state_d     = START;
              shift_d     = hold;
              hold_full_d = 1'b0;
            end else begin
              state_d = CARRIER;
            end
          end
        endcase
      end
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      acc       <= '0;
      cell_cnt  <= '0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      tape_out  <= 1'b0;
    end else begin
      state     <= state_d;
      acc       <= acc_d;
      cell_cnt  <= cell_d;
      bit_idx   <= bit_d;
      stop_cnt  <= stop_d;
      shift     <= shift_d;
      hold      <= hold_d;
      hold_full <= hold_full_d;
      tape_out  <= tape_d;
    end
  end

endmodule
